// File: rtl/reaction_referee.sv
// Judges each reaction-game round (false starts, winner, reaction time) and keeps saturating scores.
// Results register 3 clk edges after a raw switch is first sampled high; there is no backpressure on the result outputs.
module reaction_referee #(
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 5,
  parameter int TIMEOUT_MS = 2000,
  parameter int RT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               arm,
  input  logic               go,
  input  logic               sw_p1,
  input  logic               sw_p2,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         round_winner,
  output logic [1:0]         false_start,
  output logic [RT_W-1:0]    reaction_ms,
  output logic               result_valid,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] S_ONE  = SCORE_W'(1);
  localparam logic [RT_W-1:0]    TMO    = RT_W'(TIMEOUT_MS);
  localparam logic [RT_W-1:0]    RT_ONE = RT_W'(1);
  localparam logic [RT_W-1:0]    RT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ARMED, LIVE, RESULT, DONE} state_t;

  state_t             state, state_n;
  logic [1:0]         p1_sync, p2_sync;
  logic               p1_prev, p2_prev;
  logic               flip1, flip2;
  logic [RT_W-1:0]    ms_cnt, ms_cnt_n;
  logic [SCORE_W-1:0] p1_score_n, p2_score_n;
  logic [1:0]         round_winner_n, false_start_n;
  logic [RT_W-1:0]    reaction_ms_n;
  logic               result_valid_n;

  // Only rising edges of the synchronised level count, so a switch already high at arm is not a flip.
  assign flip1 = p1_sync[1] & ~p1_prev;
  assign flip2 = p2_sync[1] & ~p2_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      p1_sync      <= 2'b00;
      p2_sync      <= 2'b00;
      p1_prev      <= 1'b0;
      p2_prev      <= 1'b0;
      ms_cnt       <= '0;
      p1_score     <= '0;
      p2_score     <= '0;
      round_winner <= 2'b00;
      false_start  <= 2'b00;
      reaction_ms  <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      p1_sync      <= {p1_sync[0], sw_p1};
      p2_sync      <= {p2_sync[0], sw_p2};
      p1_prev      <= p1_sync[1];
      p2_prev      <= p2_sync[1];
      ms_cnt       <= ms_cnt_n;
      p1_score     <= p1_score_n;
      p2_score     <= p2_score_n;
      round_winner <= round_winner_n;
      false_start  <= false_start_n;
      reaction_ms  <= reaction_ms_n;
      result_valid <= result_valid_n;
    end
  end

  always_comb begin
    state_n        = state;
    ms_cnt_n       = ms_cnt;
    p1_score_n     = p1_score;
    p2_score_n     = p2_score;
    round_winner_n = round_winner;
    false_start_n  = false_start;
    reaction_ms_n  = reaction_ms;
    result_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_n        = ARMED;
          round_winner_n = 2'b00;
          false_start_n  = 2'b00;
          reaction_ms_n  = '0;
          ms_cnt_n       = '0;
        end
      end
      ARMED: begin
        // A flip in the same cycle go is seen is still a false start.
        if (flip1 || flip2) begin
          if (flip1 && p1_score != '0) p1_score_n = p1_score - S_ONE;
          if (flip2 && p2_score != '0) p2_score_n = p2_score - S_ONE;
          false_start_n  = {flip2, flip1};
          round_winner_n = 2'b00;
          result_valid_n = 1'b1;
          state_n        = RESULT;
        end else if (go) begin
          state_n = LIVE;
        end
      end
      LIVE: begin
        if (ms_cnt >= TMO) begin
          round_winner_n = 2'b00;
          reaction_ms_n  = TMO;
          result_valid_n = 1'b1;
          state_n        = RESULT;
        end else if (flip1 || flip2) begin
          round_winner_n = {flip2, flip1};
          reaction_ms_n  = ms_cnt;
          result_valid_n = 1'b1;
          state_n        = RESULT;
          if (flip1 && !flip2 && p1_score != WIN) p1_score_n = p1_score + S_ONE;
          if (flip2 && !flip1 && p2_score != WIN) p2_score_n = p2_score + S_ONE;
        end else if (tick && ms_cnt != RT_MAX) begin
          ms_cnt_n = ms_cnt + RT_ONE;
        end
      end
      RESULT: begin
        if (p1_score == WIN || p2_score == WIN) begin
          state_n = DONE;
        end else if (arm) begin
          state_n        = ARMED;
          round_winner_n = 2'b00;
          false_start_n  = 2'b00;
          reaction_ms_n  = '0;
          ms_cnt_n       = '0;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign match_over   = (state == DONE);
  assign match_winner = (state != DONE)   ? 2'b00 :
                        (p1_score == WIN) ? 2'b01 :
                        (p2_score == WIN) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_reaction_referee.sv
// Randomised scoreboard bench for reaction_referee: rounds are modelled at the rule level and
// published results are checked by an independent monitor.
module tb_reaction_referee;

  localparam int WIN = 5;
  localparam int TMO = 2000;

  logic        clk = 1'b0;
  logic        reset, tick, arm, go, sw_p1, sw_p2;
  logic [3:0]  p1_score, p2_score;
  logic [1:0]  round_winner, false_start, match_winner;
  logic [15:0] reaction_ms;
  logic        result_valid, match_over;

  always #5 clk = ~clk;

  reaction_referee #(
    .SCORE_W(4), .WIN_SCORE(WIN), .TIMEOUT_MS(TMO), .RT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .arm(arm), .go(go),
    .sw_p1(sw_p1), .sw_p2(sw_p2),
    .p1_score(p1_score), .p2_score(p2_score),
    .round_winner(round_winner), .false_start(false_start),
    .reaction_ms(reaction_ms), .result_valid(result_valid),
    .match_over(match_over), .match_winner(match_winner)
  );

  typedef struct {
    int rw;
    int fs;
    int rms;
    int p1;
    int p2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   p1m = 0;
  int   p2m = 0;
  int   timeouts = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every published result must match the oldest expected one.
  always @(negedge clk) begin
    if (result_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("round_winner", int'(round_winner), mon_e.rw);
        chk("false_start",  int'(false_start),  mon_e.fs);
        chk("reaction_ms",  int'(reaction_ms),  mon_e.rms);
        chk("p1_score",     int'(p1_score),     mon_e.p1);
        chk("p2_score",     int'(p2_score),     mon_e.p2);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    chk("rst_p1_score",     int'(p1_score),     0);
    chk("rst_p2_score",     int'(p2_score),     0);
    chk("rst_round_winner", int'(round_winner), 0);
    chk("rst_false_start",  int'(false_start),  0);
    chk("rst_reaction_ms",  int'(reaction_ms),  0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_match_over",   int'(match_over),   0);
    chk("rst_match_winner", int'(match_winner), 0);
    reset = 1'b0;
    p1m = 0;
    p2m = 0;
    step(1);
  endtask

  // kind: 0 P1 jumps, 1 P2 jumps, 2 both jump, 3 P1 flip lands with go,
  //       4 P1 wins, 5 P2 wins, 6 tie, 7 timeout
  task automatic play(input int kind, input int pre, input int nt);
    exp_t e;
    int   j1, j2;
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(1);
    do_ticks(pre);
    e.rw = 0; e.fs = 0; e.rms = 0;
    if (kind <= 3) begin
      j1 = (kind == 0 || kind == 2 || kind == 3) ? 1 : 0;
      j2 = (kind == 1 || kind == 2) ? 1 : 0;
      if (j1 == 1 && p1m > 0) p1m--;
      if (j2 == 1 && p2m > 0) p2m--;
      e.fs = j2 * 2 + j1;
      e.p1 = p1m; e.p2 = p2m;
      q.push_back(e);
      if (j1 == 1) sw_p1 = 1'b1;
      if (j2 == 1) sw_p2 = 1'b1;
      if (kind == 3) begin
        step(2);
        go = 1'b1;
      end
      step(4);
    end else begin
      go = 1'b1;
      step(2);
      if (kind == 7) begin
        e.rms = TMO;
        e.p1 = p1m; e.p2 = p2m;
        q.push_back(e);
        do_ticks(TMO);
      end else begin
        do_ticks(nt);
        e.rms = nt;
        if (kind == 4) begin
          e.rw = 1;
          if (p1m < WIN) p1m++;
          sw_p1 = 1'b1;
        end else if (kind == 5) begin
          e.rw = 2;
          if (p2m < WIN) p2m++;
          sw_p2 = 1'b1;
        end else begin
          e.rw = 3;
          sw_p1 = 1'b1;
          sw_p2 = 1'b1;
        end
        e.p1 = p1m; e.p2 = p2m;
        q.push_back(e);
      end
      step(4);
    end
    chk("result_arrived", q.size(), 0);
    go = 1'b0;
    sw_p1 = 1'b0;
    sw_p2 = 1'b0;
    step(4);
  endtask

  task automatic check_match();
    if (p1m == WIN || p2m == WIN) begin
      step(2);
      chk("match_over",   int'(match_over),   1);
      chk("match_winner", int'(match_winner), (p1m == WIN) ? 1 : 2);
      // Everything but reset is ignored once the match is decided.
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      go = 1'b1;
      do_ticks(3);
      sw_p1 = 1'b1;
      sw_p2 = 1'b1;
      step(6);
      chk("done_p1_hold",     int'(p1_score),   p1m);
      chk("done_p2_hold",     int'(p2_score),   p2m);
      chk("done_match_over",  int'(match_over), 1);
      go = 1'b0;
      sw_p1 = 1'b0;
      sw_p2 = 1'b0;
      step(3);
      do_reset();
    end
  endtask

  task automatic round(input int kind, input int pre, input int nt);
    play(kind, pre, nt);
    check_match();
  endtask

  initial begin
    int kind;
    reset = 1'b1; tick = 1'b0; arm = 1'b0; go = 1'b0; sw_p1 = 1'b0; sw_p2 = 1'b0;
    step(2);
    do_reset();

    round(4, 50, 37);
    round(5, 3, 10);
    round(5, 4, 22);
    round(1, 5, 0);
    round(1, 2, 0);
    round(1, 2, 0);
    round(6, 5, 12);
    round(7, 2, 0);
    timeouts++;
    round(3, 4, 0);
    round(2, 3, 0);

    round(4, 1, 5);
    round(4, 1, 6);
    round(4, 1, 7);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    go = 1'b1;
    step(2);
    do_ticks(10);
    sw_p1 = 1'b1;
    do_reset();
    go = 1'b0;
    step(5);
    round(5, 3, 20);

    for (int r = 0; r < 5; r++) round(4, 2, 1 + r);

    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 6);
      if (timeouts < 2 && $urandom_range(0, 19) == 0) begin
        kind = 7;
        timeouts++;
      end
      round(kind, $urandom_range(0, 20), $urandom_range(0, 80));
    end

    step(5);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
